// File: rtl/spram_req_ctrl_pkg.sv
// spram_req_ctrl_pkg: shared FSM state type and width helpers for the SPRAM request controller
package spram_req_ctrl_pkg;
  typedef enum logic {IDLE, RMW} state_t;
  function automatic int bw_of(input int dw);
    return dw / 8;
  endfunction
  function automatic int cw_of(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/spram_rsp_fifo.sv
// spram_rsp_fifo: DEPTH-entry synchronous response FIFO with occupancy count, push+pop at full allowed
module spram_rsp_fifo #(
  parameter int DW = 16,
  parameter int DEPTH = 2,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic          valid,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] cnt
);
  localparam int PW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (pop) rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  assign valid = cnt != '0;
  assign dout  = mem[rptr];
endmodule

// File: rtl/spram_req_ctrl.sv
// spram_req_ctrl: valid/ready front-end for a 1-cycle-latency single-port RAM, byte-masked RMW writes with SPRAM_CTRL_BE_EN
module spram_req_ctrl
  import spram_req_ctrl_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 10,
  parameter int RSP_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
`ifdef SPRAM_CTRL_BE_EN
  input  logic [DW/8-1:0] req_be,
`endif
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_data,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_din,
  input  logic [DW-1:0]   mem_dout
);
  localparam int CW = cw_of(RSP_DEPTH);
  logic          pop, accept, credit_ok, rd_pend;
  logic [CW-1:0] cnt;
  logic [CW:0]   used;
  state_t        state, state_nx;
  assign pop       = rsp_valid && rsp_ready;
  assign used      = {1'b0, cnt} + (CW+1)'(rd_pend) - (CW+1)'(pop);
  assign credit_ok = used < (CW+1)'(RSP_DEPTH);
  assign accept    = req_valid && req_ready;
  spram_rsp_fifo #(.DW(DW), .DEPTH(RSP_DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_pend),
    .din   (mem_dout),
    .pop   (pop),
    .valid (rsp_valid),
    .dout  (rsp_data),
    .cnt   (cnt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend <= 1'b0;
      state   <= IDLE;
    end else begin
      rd_pend <= accept && !req_we;
      state   <= state_nx;
    end
  end
`ifdef SPRAM_CTRL_BE_EN
  localparam int BW = bw_of(DW);
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata, merged;
  logic [BW-1:0] l_be;
  logic          be_full, be_none, partial;
  assign be_full = &req_be;
  assign be_none = ~|req_be;
  assign partial = req_we && !be_full && !be_none;
  always_ff @(posedge clk) begin
    if (accept && partial) begin
      l_addr  <= req_addr;
      l_wdata <= req_wdata;
      l_be    <= req_be;
    end
  end
  always_comb begin
    merged = mem_dout;
    for (int i = 0; i < BW; i++) merged[8*i +: 8] = l_be[i] ? l_wdata[8*i +: 8] : mem_dout[8*i +: 8];
  end
  always_comb begin
    state_nx  = (state == IDLE && accept && partial) ? RMW : IDLE;
    req_ready = !rst && state == IDLE && (req_we ? (!partial || !rd_pend) : credit_ok);
    mem_en    = (state == RMW) ? !rst : accept && !(req_we && be_none);
    mem_we    = (state == RMW) ? !rst : accept && req_we && be_full;
    mem_addr  = (state == RMW) ? l_addr : req_addr;
    mem_din   = (state == RMW) ? merged : req_wdata;
  end
`else
  always_comb begin
    state_nx  = IDLE;
    req_ready = !rst && state == IDLE && (req_we || credit_ok);
    mem_en    = accept;
    mem_we    = accept && req_we;
    mem_addr  = req_addr;
    mem_din   = req_wdata;
  end
`endif
endmodule

// File: tb/tb_spram_req_ctrl.sv
// tb_spram_req_ctrl: scoreboard bench for spram_req_ctrl with a behavioural RAM, covers SPRAM_CTRL_BE_EN when defined
module tb_spram_req_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_ready = 1'b1;
`ifdef SPRAM_CTRL_BE_EN
  logic [1:0]  req_be = 2'b11;
`endif
  logic        req_ready, rsp_valid, mem_en, mem_we;
  logic [15:0] rsp_data, mem_din, mem_dout;
  logic [9:0]  mem_addr;
  logic [15:0] ram [1024];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] q[$];

  always #5 clk = ~clk;

  spram_req_ctrl #(.DW(16), .AW(10), .RSP_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef SPRAM_CTRL_BE_EN
    .req_be    (req_be),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      else mem_dout <= ram[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected: got %h expected no response", rsp_data);
      end else chk("rsp_data", {16'h0, rsp_data}, {16'h0, q.pop_front()});
    end
  end

  task automatic issue(input logic we, input logic [9:0] a, input logic [15:0] d, input logic [15:0] e);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
`ifdef SPRAM_CTRL_BE_EN
    req_be = 2'b11;
`endif
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("issue_timeout", {31'h0, req_ready}, 32'h1);
    else if (!we) q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1 chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    req_valid = 1'b1;
    req_we    = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 0);
    chk("rst_mem_en", {31'h0, mem_en}, 0);
    chk("rst_mem_we", {31'h0, mem_we}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid = 1'b0;
    issue(1'b1, 10'd5, 16'hA5A5, 16'h0);
    issue(1'b0, 10'd5, 16'h0, 16'hA5A5);
    @(negedge clk);
    chk("lat1_valid", {31'h0, rsp_valid}, 0);
    @(negedge clk);
    chk("lat2_valid", {31'h0, rsp_valid}, 1);
    chk("lat2_data", {16'h0, rsp_data}, 32'hA5A5);
    drain();
    for (int i = 0; i < 16; i++) issue(1'b1, 10'(i), 16'(16'hC000 + i), 16'h0);
    for (int k = 0; k < 10; k++) begin
      req_valid = k < 8;
      req_we    = 1'b0;
      req_addr  = 10'(k);
      @(negedge clk);
      if (k < 8) begin
        chk("b2b_ready", {31'h0, req_ready}, 1);
        q.push_back(16'(16'hC000 + k));
      end
      chk("b2b_valid", {31'h0, rsp_valid}, {31'h0, k >= 2});
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    drain();
    rsp_ready = 1'b0;
    issue(1'b0, 10'd10, 16'h0, 16'hC00A);
    issue(1'b0, 10'd11, 16'h0, 16'hC00B);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 10'd12;
    repeat (3) begin
      @(negedge clk);
      chk("full_ready", {31'h0, req_ready}, 0);
    end
    chk("full_valid", {31'h0, rsp_valid}, 1);
    chk("full_data", {16'h0, rsp_data}, 32'hC00A);
    @(posedge clk);
    #1 req_we = 1'b1;
    req_addr  = 10'd20;
    req_wdata = 16'h2020;
    @(negedge clk);
    chk("wr_full_ready", {31'h0, req_ready}, 1);
    @(posedge clk);
    #1 req_we = 1'b0;
    req_addr = 10'd12;
    @(negedge clk);
    chk("full_data_hold", {16'h0, rsp_data}, 32'hC00A);
    chk("full_ready_again", {31'h0, req_ready}, 0);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", {31'h0, req_ready}, 1);
    q.push_back(16'hC00C);
    @(posedge clk);
    #1 req_valid = 1'b0;
    drain();
    issue(1'b0, 10'd20, 16'h0, 16'h2020);
    drain();
`ifdef SPRAM_CTRL_BE_EN
    issue(1'b1, 10'd3, 16'h1234, 16'h0);
    repeat (2) @(posedge clk);
    #1 req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 10'd3;
    req_wdata = 16'hABCD;
    req_be    = 2'b01;
    @(negedge clk);
    chk("be_ready", {31'h0, req_ready}, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_be = 2'b11;
    @(negedge clk);
    chk("rmw_ready", {31'h0, req_ready}, 0);
    chk("rmw_we", {31'h0, mem_we}, 1);
    chk("rmw_addr", {22'h0, mem_addr}, 3);
    chk("rmw_din", {16'h0, mem_din}, 32'h12CD);
    @(posedge clk);
    @(negedge clk);
    chk("rmw_done_ready", {31'h0, req_ready}, 1);
    @(posedge clk);
    #1 issue(1'b0, 10'd3, 16'h0, 16'h12CD);
    drain();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 10'd3;
    req_wdata = 16'h0000;
    req_be    = 2'b00;
    @(negedge clk);
    chk("be0_ready", {31'h0, req_ready}, 1);
    chk("be0_en", {31'h0, mem_en}, 0);
    @(posedge clk);
    #1 req_wdata = 16'hFFFF;
    req_be = 2'b10;
    @(negedge clk);
    chk("be_part_ready", {31'h0, req_ready}, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rmw_en", {31'h0, mem_en}, 0);
    chk("rst_rmw_ready", {31'h0, req_ready}, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_rmw_valid", {31'h0, rsp_valid}, 0);
    chk("rst_hold_ready", {31'h0, req_ready}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    req_be = 2'b11;
    issue(1'b0, 10'd3, 16'h0, 16'h12CD);
    drain();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
